// File: rtl/axi4lite_cmd_master.sv
// Command-stream to AXI4-Lite master: one outstanding single-beat transaction, one response per command.
// Optional watchdog enabled with `define AXIL_MST_TIMEOUT_EN (timeout reported as rsp_resp 2'b11).
module axi4lite_cmd_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command / response streams
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    // AXI4-Lite write channels
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // AXI4-Lite read channels
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t state, state_d;

    logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_d, rsp_rdata_d;
    logic                  rsp_valid_d, rsp_write_d;
    logic [1:0]            rsp_resp_d;

    logic cmd_acc, aw_ok, w_ok, ar_ok, b_acc, r_acc, tmo_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign cmd_acc = cmd_valid & cmd_ready;
    // A VALID only ever drops through its handshake, so "low or handshaking now" means that channel is done.
    assign aw_ok   = ~AWVALID | AWREADY;
    assign w_ok    = ~WVALID  | WREADY;
    assign ar_ok   = ~ARVALID | ARREADY;
    assign b_acc   = (state == WRITE) & BREADY & BVALID & aw_ok & w_ok;
    assign r_acc   = (state == READ)  & RREADY & RVALID & ar_ok;

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            tmo_cnt <= '0;
        else if (state == IDLE)
            tmo_cnt <= '0;
        else if (state == WRITE || state == READ)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == WRITE || state == READ) && (tmo_cnt == TMO_LAST) && !b_acc && !r_acc;
`else
    assign tmo_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (cmd_acc) state_d = cmd_write ? WRITE : READ;
            WRITE: if (b_acc || tmo_hit) state_d = RESP;
            READ:  if (r_acc || tmo_hit) state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        awvalid_d   = AWVALID;
        wvalid_d    = WVALID;
        bready_d    = BREADY;
        arvalid_d   = ARVALID;
        rready_d    = RREADY;
        awaddr_d    = AWADDR;
        araddr_d    = ARADDR;
        wdata_d     = WDATA;
        rsp_valid_d = rsp_valid;
        rsp_write_d = rsp_write;
        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    rsp_write_d = cmd_write;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (AWVALID && AWREADY) awvalid_d = 1'b0;
                if (WVALID && WREADY)   wvalid_d  = 1'b0;
                if (b_acc) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = BRESP;
                    rsp_rdata_d = '0;
                end
            end
            READ: begin
                if (ARVALID && ARREADY) arvalid_d = 1'b0;
                if (r_acc) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = RRESP;
                    rsp_rdata_d = RDATA;
                end
            end
            RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
        // watchdog abandons the bus transaction and reports 2'b11
        if (tmo_hit) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = 2'b11;
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            AWADDR    <= '0;
            ARADDR    <= '0;
            WDATA     <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            cmd_ready <= 1'b1;
        end else begin
            AWVALID   <= awvalid_d;
            WVALID    <= wvalid_d;
            BREADY    <= bready_d;
            ARVALID   <= arvalid_d;
            RREADY    <= rready_d;
            AWADDR    <= awaddr_d;
            ARADDR    <= araddr_d;
            WDATA     <= wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_write <= rsp_write_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_resp  <= rsp_resp_d;
            cmd_ready <= (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Bench for axi4lite_cmd_master: reactive 4-register slave model plus response scoreboard.
// Define AXIL_MST_TIMEOUT_EN for both RTL and bench to include the watchdog case.
module tb_axi4lite_cmd_master;

    logic        ACLK, ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [1:0]  BRESP, RRESP;

    axi4lite_cmd_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model (drives on the falling edge) ----------------
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    bit          never_b = 0;
    logic [1:0]  s_resp = 2'b00;
    logic [31:0] smem [4] = '{default: 32'h0};
    int          aw_cnt, w_cnt, ar_cnt;
    bit          have_aw, have_w, have_ar, p_b, p_r;
    logic [3:0]  s_awaddr, last_araddr;
    logic [31:0] s_wdata;
    int          aw_hi = 0, w_hi = 0, b_hi = 0, b_cnt = 0;

    always @(negedge ACLK) begin
        if (ARESET) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            BRESP = 0; RRESP = 0; RDATA = 0;
            have_aw = 0; have_w = 0; have_ar = 0; p_b = 0; p_r = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            if (AWVALID) aw_hi++;
            if (WVALID)  w_hi++;
            if (BREADY)  b_hi++;
            if (p_b) begin BVALID = 0; b_cnt++; end
            if (p_r) RVALID = 0;
            if (!BREADY) begin have_aw = 0; have_w = 0; aw_cnt = 0; w_cnt = 0; end
            if (!RREADY) begin have_ar = 0; ar_cnt = 0; end
            AWREADY = 0; WREADY = 0; ARREADY = 0;
            if (AWVALID && !have_aw) begin AWREADY = (aw_cnt >= aw_lat); aw_cnt++; end
            if (WVALID  && !have_w)  begin WREADY  = (w_cnt  >= w_lat);  w_cnt++;  end
            if (ARVALID && !have_ar) begin ARREADY = (ar_cnt >= ar_lat); ar_cnt++; end
            if (AWVALID && AWREADY) begin have_aw = 1; s_awaddr = AWADDR; end
            if (WVALID && WREADY)   begin have_w = 1;  s_wdata  = WDATA;  end
            if (ARVALID && ARREADY) begin have_ar = 1; last_araddr = ARADDR; end
            if (have_aw && have_w && BREADY && !BVALID && !never_b) begin
                smem[s_awaddr[3:2]] = s_wdata;
                BVALID = 1; BRESP = s_resp;
            end
            if (have_ar && RREADY && !RVALID) begin
                RVALID = 1; RDATA = smem[last_araddr[3:2]]; RRESP = s_resp;
            end
            p_b = BVALID & BREADY;
            p_r = RVALID & RREADY;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic w; logic [31:0] d; logic [1:0] r; } exp_t;
    exp_t        sb[$];
    logic [31:0] ref_mem [4] = '{default: 32'h0};

    always @(negedge ACLK) begin
        if (!ARESET && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_rsp", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_write", rsp_write, e.w);
                chk("rsp_rdata", rsp_rdata, e.d);
                chk("rsp_resp",  rsp_resp,  e.r);
            end
        end
    end

    // drives a command until accepted and pushes its expected response
    task automatic issue(input bit w, input logic [3:0] a, input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        bit   ok = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            ok = cmd_ready;
        end
        if (!ok) chk("cmd_accept_timeout", 0, 1);
        e.w = w; e.r = r;
        if (w) begin
            e.d = 32'h0;
            if (r != 2'b11) ref_mem[a[3:2]] = d;
        end else
            e.d = (r == 2'b11) ? 32'h0 : ref_mem[a[3:2]];
        if (ok) sb.push_back(e);
        @(posedge ACLK); #1;
        cmd_valid = 0;
    endtask

    // waits for the response handshake; lat counts falling edges from acceptance
    task automatic wait_rsp(input bit busy, output int lat);
        bit ok = 0;
        lat = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge ACLK);
            lat++;
            if (busy) chk("busy_cmd_ready", cmd_ready, 0);
            ok = rsp_valid && rsp_ready;
        end
        if (!ok) chk("rsp_timeout", 0, 1);
        @(posedge ACLK); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat, a0, w0, b0;
        logic [31:0] save, d;
        logic [3:0]  a;
        bit          w;
        ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_addr_data", {AWADDR, ARADDR, WDATA}, 0);
        chk("rst_rsp_fields", {rsp_rdata, rsp_resp}, 0);
        ARESET = 0;
        @(posedge ACLK); #1;

        // T1: write then read back, with latency
        issue(1, 4'h4, 32'hDEADBEEF, 2'b00);
        wait_rsp(1, lat);
        chk("t1_wr_latency", lat, 2);
        chk("t1_cmd_ready_after", cmd_ready, 1);
        issue(0, 4'h4, 32'h0, 2'b00);
        wait_rsp(1, lat);
        chk("t1_rd_latency", lat, 2);

        // T2: fill all four registers then read them back
        for (int i = 0; i < 4; i++) begin
            issue(1, 4'(i * 4), 32'(8'h11 * (i + 1)), 2'b00);
            wait_rsp(1, lat);
        end
        for (int i = 0; i < 4; i++) begin
            issue(0, 4'(i * 4), 32'h0, 2'b00);
            wait_rsp(1, lat);
        end

        // T3: W channel stalls 3 cycles, AW immediate
        w_lat = 3; a0 = aw_hi; w0 = w_hi; b0 = b_cnt;
        issue(1, 4'h0, 32'h77, 2'b00);
        wait_rsp(1, lat);
        chk("t3_awvalid_cycles", aw_hi - a0, 1);
        chk("t3_wvalid_cycles", w_hi - w0, 4);
        chk("t3_b_beats", b_cnt - b0, 1);
        w_lat = 0;
        issue(0, 4'h0, 32'h0, 2'b00);
        wait_rsp(0, lat);

        // T4: response back-pressure holds fields stable
        issue(1, 4'hC, 32'hCAFEF00D, 2'b00);
        wait_rsp(0, lat);
        rsp_ready = 0;
        issue(0, 4'hC, 32'h0, 2'b00);
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(negedge ACLK); lat++; end
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_rdata", rsp_rdata, 32'hCAFEF00D);
            chk("t4_hold_cmd_ready", cmd_ready, 0);
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        rsp_ready = 1;
        wait_rsp(0, lat);

        // slave error response is passed through; unaligned address forwarded as-is
        s_resp = 2'b10;
        issue(1, 4'h4, 32'hA5A5_0001, 2'b10);
        wait_rsp(0, lat);
        issue(0, 4'h5, 32'h0, 2'b10);
        wait_rsp(0, lat);
        chk("unaligned_araddr", last_araddr, 4'h5);
        s_resp = 2'b00;

        // T5: reset during an in-flight write
        aw_lat = 5; w_lat = 5; save = ref_mem[2];
        issue(1, 4'h8, 32'h5555_5555, 2'b00);
        #2 ARESET = 1;
        #1;
        chk("t5_async_clear", {AWVALID, WVALID, BREADY}, 0);
        chk("t5_async_cmd_ready", cmd_ready, 1);
        @(posedge ACLK); #1;
        ARESET = 0;
        sb.delete();
        ref_mem[2] = save;
        aw_lat = 0; w_lat = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("t5_no_rsp", rsp_valid, 0);
            chk("t5_cmd_ready", cmd_ready, 1);
        end
        @(posedge ACLK); #1;
        issue(0, 4'h8, 32'h0, 2'b00);
        wait_rsp(0, lat);

        // random mix with random slave stalls and responses
        for (int k = 0; k < 12; k++) begin
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
            s_resp = 2'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1)); a = 4'($urandom_range(0, 15)); d = $urandom;
            issue(w, a, d, s_resp);
            wait_rsp(1, lat);
        end
        aw_lat = 0; w_lat = 0; ar_lat = 0; s_resp = 2'b00;

`ifdef AXIL_MST_TIMEOUT_EN
        // T6: slave never answers the write
        never_b = 1; b0 = b_hi;
        issue(1, 4'h0, 32'h99, 2'b11);
        wait_rsp(0, lat);
        chk("t6_bready_cycles", b_hi - b0, 16);
        chk("t6_valids_low", {AWVALID, WVALID, BREADY}, 0);
        never_b = 0;
`endif

        repeat (3) @(posedge ACLK);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
